axis_tb_str_port: RTL and testbench
===================================

Name: axis_tb_str_port

Overview:
- Synthesizable AXI4-Stream traffic port for the system-level bench.
- Replaces the fixed "tready tied high" stream sink and "tvalid tied low" stream source with a parametrised generator and a self-checking sink per stream channel.
- The generator drives a TX stream with a deterministic byte pattern in packets. The checker consumes an RX stream, applies configurable backpressure, verifies the pattern and tlast, and counts packets and errors.

Parameters:
- DN, 2: data lanes (bytes) per beat.
- DW, 8: bits per lane.
- LW, 16: width of the length, packet-count and statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle pulse; arms generator and checker.
- cfg_stop  in  1  single-cycle pulse; generator ends at the next packet boundary.
- cfg_len  in  LW  packet length in bytes; 0 = illegal, start ignored.
- cfg_pkts  in  LW  packets to send; 0 = continuous.
- cfg_seed  in  DW  first byte value.
- cfg_bp  in  2  RX backpressure mode: 0 always ready, 1 ready every other cycle, 2 LFSR, 3 never ready.
- tx_tdata  out  DN*DW  generator data; lane l in bits [l*DW +: DW].
- tx_tkeep  out  DN  generator byte enables.
- tx_tlast  out  1  last beat of packet.
- tx_tvalid  out  1  generator valid.
- tx_tready  in  1  downstream ready.
- rx_tdata  in  DN*DW  checker data.
- rx_tkeep  in  DN  checker byte enables.
- rx_tlast  in  1  checker last.
- rx_tvalid  in  1  checker valid.
- rx_tready  out  1  checker ready.
- tx_busy  out  1  generator not idle.
- stat_pkt  out  LW  RX packets completed (saturating).
- stat_err  out  LW  RX errors (saturating).

Behaviour:
- Reset: all outputs 0; tx_tvalid=0, rx_tready=0; byte counters = 0; generator FSM in IDLE; LFSR = all ones. rst takes effect in the cycle it is sampled, including mid-packet; a partial packet is abandoned without tlast.
- cfg_start while IDLE with cfg_len != 0:
  - Latch len, pkts and seed.
  - Clear both byte counters to the seed and clear stats.
  - Generator moves IDLE -> SEND. Checker arms.
- cfg_start while not IDLE: ignored.
- Generator FSM:
  - IDLE: tx_tvalid=0.
  - SEND:
    - tx_tvalid=1 from the first cycle after start (latency 1).
    - Beat lane l = tx_bytecnt + l (mod 2^DW). Lanes are packed from lane 0.
    - Bytes remaining in packet r: tkeep = all ones if r >= DN, else (1<<r)-1.
    - tx_tlast=1 when r <= DN.
  - Handshake: data, keep and last hold stable while tvalid && !tready. State advances only on tvalid && tready.
  - On each accepted beat: tx_bytecnt += popcount(tkeep); in-packet remainder -= popcount(tkeep).
  - On an accepted tlast beat: sent += 1. Go to IDLE if sent == pkts (pkts != 0) or a stop is pending; otherwise reload the remainder from len and stay in SEND with no bubble.
  - cfg_stop in IDLE is ignored. A stop received in SEND is held until the packet boundary.
  - tx_busy = (state != IDLE).
- Checker:
  - rx_tready follows cfg_bp, registered (one-cycle latency from mode change).
  - Mode 1 toggles every cycle starting at 1.
  - Mode 2 = bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11), stepped every cycle.
  - On rx_tvalid && rx_tready:
    - Each kept lane l is compared to rx_bytecnt + k, where k = count of kept lanes below l.
    - rx_bytecnt += popcount(rx_tkeep).
    - rx_inpkt += popcount(rx_tkeep).
  - Error per beat (at most +1 per beat):
    - any lane mismatch;
    - tlast asserted with rx_inpkt_new != len;
    - tlast absent with rx_inpkt_new >= len;
    - non-contiguous tkeep (a 1 above a 0);
    - tkeep == 0.
  - On tlast: stat_pkt += 1; rx_inpkt = 0.
  - Both stats saturate at 2^LW-1.
  - Checker runs independently of generator state; it keeps checking after the generator returns to IDLE.
- Wrap-around: byte counters wrap mod 2^DW; the pattern continues across packet boundaries.

Optional Feature:
- Macro AXIS_TB_GAP_EN.
- When defined:
  - Extra input cfg_gap [LW-1:0].
  - After each accepted tlast beat, the generator holds tx_tvalid=0 for cfg_gap cycles. This adds a GAP state: SEND -> GAP -> SEND, or GAP -> IDLE if finished.
  - A stop during GAP ends in IDLE.
- When undefined: no port, no GAP state; packets are back-to-back.

Test Plan:
- Loopback TX->RX, DN=2, len=6, pkts=3, seed=0x10, bp=0 -> 9 beats, tkeep=11 throughout, bytes 0x10..0x21 in order, tlast on beats 3/6/9, stat_pkt=3, stat_err=0, tx_busy drops 1 cycle after the 9th beat.
- Loopback, len=5, pkts=2, bp=2 -> beats 3/6 carry tkeep=01 with tlast, data stable during every tready=0 stall, stat_pkt=2, stat_err=0.
- Loopback, seed=0xFE, len=4, pkts=1 -> bytes FE,FF,00,01; no errors across the wrap.
- Bench drives RX directly, len=4: beat {0x01,0x00} with expected 0x00, then an early tlast on the 2nd beat -> stat_err=2, stat_pkt=1.
- pkts=0, cfg_stop mid-packet, then rst asserted during a later start -> generator finishes the current packet then IDLE; after rst all outputs 0 and stats 0 the next cycle.
- With AXIS_TB_GAP_EN, cfg_gap=3, len=2, pkts=2 -> exactly 3 tvalid=0 cycles between packets; without the macro -> 0 cycles.

Source files
------------

// File: rtl/axis_tb_str_port.sv
//==============================================================================
// Module   : axis_tb_str_port
// Purpose  : AXI4-Stream traffic port. TX side is a packetised byte-pattern
//            generator; RX side is a self-checking sink with selectable
//            backpressure, packet and error statistics.
// Options  : define AXIS_TB_GAP_EN to add the cfg_gap input and an idle
//            gap of cfg_gap cycles after every generated packet.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_tb_str_port #(
   parameter int DN = 2,
   parameter int DW = 8,
   parameter int LW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_stop,
   input  logic [LW-1:0]    cfg_len,
   input  logic [LW-1:0]    cfg_pkts,
   input  logic [DW-1:0]    cfg_seed,
   input  logic [1:0]       cfg_bp,
`ifdef AXIS_TB_GAP_EN
   input  logic [LW-1:0]    cfg_gap,
`endif
   output logic [DN*DW-1:0] tx_tdata,
   output logic [DN-1:0]    tx_tkeep,
   output logic             tx_tlast,
   output logic             tx_tvalid,
   input  logic             tx_tready,
   input  logic [DN*DW-1:0] rx_tdata,
   input  logic [DN-1:0]    rx_tkeep,
   input  logic             rx_tlast,
   input  logic             rx_tvalid,
   output logic             rx_tready,
   output logic             tx_busy,
   output logic [LW-1:0]    stat_pkt,
   output logic [LW-1:0]    stat_err
);

   localparam int CW = $clog2(DN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef AXIS_TB_GAP_EN
      S_GAP  = 2'd2,
`endif
      S_SEND = 2'd1
   } state_t;

   state_t             r_state;
   state_t             w_state_nx;

   logic [LW-1:0]      r_len;
   logic [LW-1:0]      r_pkts;
   logic [LW-1:0]      r_sent;
   logic [LW-1:0]      r_tx_rem;
   logic [DW-1:0]      r_tx_bytecnt;
   logic               r_stop_pend;
`ifdef AXIS_TB_GAP_EN
   logic [LW-1:0]      r_gap;
   logic [LW-1:0]      r_gap_cnt;
`endif

   logic [LW-1:0]      w_tx_n;
   logic [DN-1:0]      w_tx_keep;
   logic [DN*DW-1:0]   w_tx_data;
   logic               w_tx_last;
   logic               w_tx_acc;
   logic               w_start;
   logic               w_done;

   logic               r_armed;
   logic               r_rdy;
   logic               r_tog;
   logic [15:0]        r_lfsr;
   logic [DW-1:0]      r_rx_bytecnt;
   logic [LW-1:0]      r_rx_inpkt;
   logic [LW-1:0]      r_stat_pkt;
   logic [LW-1:0]      r_stat_err;

   logic [CW-1:0]      w_rx_pop;
   logic               w_rx_mis;
   logic               w_rx_hole;
   logic               w_rx_zero_seen;
   logic [LW-1:0]      w_rx_inpkt_nx;
   logic               w_rx_err;
   logic               w_rx_acc;

   // A start is only honoured from IDLE and with a legal length.
   assign w_start  = cfg_start && (r_state == S_IDLE) && (cfg_len != '0);
   assign w_tx_acc = tx_tvalid && tx_tready;
   // Packet run ends on the programmed count or on a stop seen before/at tlast.
   assign w_done   = ((r_pkts != '0) && ((r_sent + LW'(1)) == r_pkts))
                     || r_stop_pend || cfg_stop;

   // Beat shaping from the remaining byte count and the running pattern byte.
   always_comb begin
      w_tx_n    = (r_tx_rem >= LW'(DN)) ? LW'(DN) : r_tx_rem;
      w_tx_last = (r_tx_rem <= LW'(DN));
      w_tx_keep = '0;
      w_tx_data = '0;
      for (int l = 0; l < DN; l++) begin
         w_tx_keep[l]          = (LW'(l) < w_tx_n);
         w_tx_data[l*DW +: DW] = r_tx_bytecnt + DW'(l);
      end
   end

   // Generator state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   // Generator next-state and valid/busy decode.
   always_comb begin
      w_state_nx = r_state;
      tx_tvalid  = 1'b0;
      tx_busy    = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_start) w_state_nx = S_SEND;
         end
         S_SEND: begin
            tx_tvalid = 1'b1;
            if (tx_tready && w_tx_last) begin
               if (w_done) w_state_nx = S_IDLE;
`ifdef AXIS_TB_GAP_EN
               else if (r_gap != '0) w_state_nx = S_GAP;
`endif
            end
         end
`ifdef AXIS_TB_GAP_EN
         S_GAP: begin
            if (cfg_stop || r_stop_pend)     w_state_nx = S_IDLE;
            else if (r_gap_cnt == LW'(1))    w_state_nx = S_SEND;
         end
`endif
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Idle bus is all zeros; while valid the beat is held by the registers.
   assign tx_tdata = tx_tvalid ? w_tx_data : '0;
   assign tx_tkeep = tx_tvalid ? w_tx_keep : '0;
   assign tx_tlast = tx_tvalid && w_tx_last;

   // Generator configuration latch, byte pattern and packet bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len        <= '0;
         r_pkts       <= '0;
         r_sent       <= '0;
         r_tx_rem     <= '0;
         r_tx_bytecnt <= '0;
         r_stop_pend  <= 1'b0;
`ifdef AXIS_TB_GAP_EN
         r_gap        <= '0;
         r_gap_cnt    <= '0;
`endif
      end else begin
         if (w_start) begin
            r_len        <= cfg_len;
            r_pkts       <= cfg_pkts;
            r_sent       <= '0;
            r_tx_rem     <= cfg_len;
            r_tx_bytecnt <= cfg_seed;
`ifdef AXIS_TB_GAP_EN
            r_gap        <= cfg_gap;
`endif
         end else if (w_tx_acc) begin
            r_tx_bytecnt <= r_tx_bytecnt + DW'(w_tx_n);
            if (w_tx_last) begin
               r_tx_rem  <= r_len;
               r_sent    <= r_sent + LW'(1);
`ifdef AXIS_TB_GAP_EN
               r_gap_cnt <= r_gap;
`endif
            end else begin
               r_tx_rem  <= r_tx_rem - w_tx_n;
            end
         end
`ifdef AXIS_TB_GAP_EN
         else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt - LW'(1);
         end
`endif
         r_stop_pend <= (r_state != S_IDLE) && (r_stop_pend || cfg_stop);
      end
   end

   // Backpressure pattern generator; ready is registered from the mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= '1;
         r_tog  <= 1'b0;
         r_rdy  <= 1'b0;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         r_tog  <= (cfg_bp == 2'd1) ? ~r_tog : 1'b0;
         case (cfg_bp)
            2'd0:    r_rdy <= 1'b1;
            2'd1:    r_rdy <= ~r_tog;
            2'd2:    r_rdy <= r_lfsr[0];
            default: r_rdy <= 1'b0;
         endcase
      end
   end

   assign rx_tready = r_rdy && r_armed;
   assign w_rx_acc  = rx_tvalid && rx_tready;

   // Per-beat check: kept lanes must continue the pattern in packed order.
   always_comb begin
      w_rx_pop       = '0;
      w_rx_mis       = 1'b0;
      w_rx_hole      = 1'b0;
      w_rx_zero_seen = 1'b0;
      for (int l = 0; l < DN; l++) begin
         if (rx_tkeep[l]) begin
            if (rx_tdata[l*DW +: DW] != (r_rx_bytecnt + DW'(w_rx_pop))) w_rx_mis = 1'b1;
            if (w_rx_zero_seen) w_rx_hole = 1'b1;
            w_rx_pop = w_rx_pop + CW'(1);
         end else begin
            w_rx_zero_seen = 1'b1;
         end
      end
      w_rx_inpkt_nx = r_rx_inpkt + LW'(w_rx_pop);
      w_rx_err      = w_rx_mis || w_rx_hole || (rx_tkeep == '0) ||
                      (rx_tlast ? (w_rx_inpkt_nx != r_len) : (w_rx_inpkt_nx >= r_len));
   end

   // Checker counters and saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_armed      <= 1'b0;
         r_rx_bytecnt <= '0;
         r_rx_inpkt   <= '0;
         r_stat_pkt   <= '0;
         r_stat_err   <= '0;
      end else if (w_start) begin
         r_armed      <= 1'b1;
         r_rx_bytecnt <= cfg_seed;
         r_rx_inpkt   <= '0;
         r_stat_pkt   <= '0;
         r_stat_err   <= '0;
      end else if (w_rx_acc) begin
         r_rx_bytecnt <= r_rx_bytecnt + DW'(w_rx_pop);
         r_rx_inpkt   <= rx_tlast ? '0 : w_rx_inpkt_nx;
         if (rx_tlast && (r_stat_pkt != '1)) r_stat_pkt <= r_stat_pkt + LW'(1);
         if (w_rx_err && (r_stat_err != '1)) r_stat_err <= r_stat_err + LW'(1);
      end
   end

   assign stat_pkt = r_stat_pkt;
   assign stat_err = r_stat_err;

endmodule

`default_nettype wire

// File: tb/tb_axis_tb_str_port.sv
//==============================================================================
// Module   : tb_axis_tb_str_port
// Purpose  : Directed bench for axis_tb_str_port: loopback and direct-RX runs
//            with hand-computed beats, stats, backpressure and reset checks.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axis_tb_str_port;

   localparam int DN = 2;
   localparam int DW = 8;
   localparam int LW = 16;
`ifdef AXIS_TB_GAP_EN
   localparam int GAP_EXP = 3;
`else
   localparam int GAP_EXP = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_start = 1'b0;
   logic             cfg_stop = 1'b0;
   logic [LW-1:0]    cfg_len = '0;
   logic [LW-1:0]    cfg_pkts = '0;
   logic [DW-1:0]    cfg_seed = '0;
   logic [1:0]       cfg_bp = '0;
`ifdef AXIS_TB_GAP_EN
   logic [LW-1:0]    cfg_gap = LW'(GAP_EXP);
`endif
   logic [DN*DW-1:0] tx_tdata;
   logic [DN-1:0]    tx_tkeep;
   logic             tx_tlast;
   logic             tx_tvalid;
   logic             tx_tready;
   logic [DN*DW-1:0] rx_tdata;
   logic [DN-1:0]    rx_tkeep;
   logic             rx_tlast;
   logic             rx_tvalid;
   logic             rx_tready;
   logic             tx_busy;
   logic [LW-1:0]    stat_pkt;
   logic [LW-1:0]    stat_err;

   // bench-side drivers used when loopback is off
   logic             loopback = 1'b1;
   logic             b_tx_tready = 1'b1;
   logic [DN*DW-1:0] b_rx_tdata = '0;
   logic [DN-1:0]    b_rx_tkeep = '0;
   logic             b_rx_tlast = 1'b0;
   logic             b_rx_tvalid = 1'b0;

   assign tx_tready = loopback ? rx_tready : b_tx_tready;
   assign rx_tdata  = loopback ? tx_tdata  : b_rx_tdata;
   assign rx_tkeep  = loopback ? tx_tkeep  : b_rx_tkeep;
   assign rx_tlast  = loopback ? tx_tlast  : b_rx_tlast;
   assign rx_tvalid = loopback ? tx_tvalid : b_rx_tvalid;

   axis_tb_str_port #(.DN(DN), .DW(DW), .LW(LW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfg_start),
      .cfg_stop  (cfg_stop),
      .cfg_len   (cfg_len),
      .cfg_pkts  (cfg_pkts),
      .cfg_seed  (cfg_seed),
      .cfg_bp    (cfg_bp),
`ifdef AXIS_TB_GAP_EN
      .cfg_gap   (cfg_gap),
`endif
      .tx_tdata  (tx_tdata),
      .tx_tkeep  (tx_tkeep),
      .tx_tlast  (tx_tlast),
      .tx_tvalid (tx_tvalid),
      .tx_tready (tx_tready),
      .rx_tdata  (rx_tdata),
      .rx_tkeep  (rx_tkeep),
      .rx_tlast  (rx_tlast),
      .rx_tvalid (rx_tvalid),
      .rx_tready (rx_tready),
      .tx_busy   (tx_busy),
      .stat_pkt  (stat_pkt),
      .stat_err  (stat_err)
   );

   always #5 clk = ~clk;

   // TX beat recorder and stall-stability watcher (sampled mid-cycle)
   int          cyc = 0;
   int          mon_n = 0;
   int          stall_bad = 0;
   int          busy_fall = -1;
   logic [15:0] mon_data [256];
   logic [1:0]  mon_keep [256];
   logic        mon_last [256];
   int          mon_cyc  [256];
   logic        p_stall = 1'b0;
   logic        p_busy = 1'b0;
   logic [15:0] p_data = '0;
   logic [1:0]  p_keep = '0;
   logic        p_last = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (tx_tvalid && tx_tready && mon_n < 256) begin
         mon_data[mon_n] <= tx_tdata;
         mon_keep[mon_n] <= tx_tkeep;
         mon_last[mon_n] <= tx_tlast;
         mon_cyc[mon_n]  <= cyc;
         mon_n           <= mon_n + 1;
      end
      if (!rst && p_stall &&
          (!tx_tvalid || tx_tdata != p_data || tx_tkeep != p_keep || tx_tlast != p_last))
         stall_bad <= stall_bad + 1;
      p_stall <= tx_tvalid && !tx_tready;
      p_data  <= tx_tdata;
      p_keep  <= tx_tkeep;
      p_last  <= tx_tlast;
      if (p_busy && !tx_busy) busy_fall <= cyc;
      p_busy  <= tx_busy;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [LW-1:0] len, input logic [LW-1:0] pkts,
                        input logic [DW-1:0] seed);
      cfg_len   = len;
      cfg_pkts  = pkts;
      cfg_seed  = seed;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n;
      n = 0;
      while (tx_busy && n < maxc) begin
         tick();
         n++;
      end
      check(tag, tx_busy, 32'd0);
   endtask

   task automatic wait_beats(input string tag, input int base, input int cnt, input int maxc);
      int n;
      n = 0;
      while ((mon_n - base) < cnt && n < maxc) begin
         tick();
         n++;
      end
      check(tag, 32'((mon_n - base) >= cnt), 32'd1);
   endtask

   task automatic rx_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
      b_rx_tdata  = d;
      b_rx_tkeep  = k;
      b_rx_tlast  = l;
      b_rx_tvalid = 1'b1;
      tick();
      b_rx_tvalid = 1'b0;
      b_rx_tlast  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tvalid"}, tx_tvalid, 32'd0);
      check({tag, "_tdata"},  tx_tdata,  32'd0);
      check({tag, "_tkeep"},  tx_tkeep,  32'd0);
      check({tag, "_tlast"},  tx_tlast,  32'd0);
      check({tag, "_rready"}, rx_tready, 32'd0);
      check({tag, "_busy"},   tx_busy,   32'd0);
      check({tag, "_spkt"},   stat_pkt,  32'd0);
      check({tag, "_serr"},   stat_err,  32'd0);
   endtask

   logic [7:0] t2_base [6] = '{8'h40, 8'h42, 8'h44, 8'h45, 8'h47, 8'h49};
   logic [1:0] t2_keep [6] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b01};

   initial begin
      int b;
      int sb;
      logic [7:0] e;

      // reset state, during and just after reset
      repeat (3) tick();
      check_all_zero("rst");
      rst = 1'b0;
      tick();
      check_all_zero("post_rst");

      // T1: loopback len=6 pkts=3 seed=0x10 always-ready
      b = mon_n;
      start(16'd6, 16'd3, 8'h10);
      wait_idle("t1_idle", 100);
      tick();
      check("t1_beats", mon_n - b, 32'd9);
      for (int i = 0; i < 9; i++) begin
         e = 8'h10 + 8'(2 * i);
         check("t1_data", {16'h0, mon_data[b+i]}, {16'h0, e + 8'd1, e});
         check("t1_keep", mon_keep[b+i], 32'd3);
         check("t1_last", mon_last[b+i], 32'((i % 3) == 2));
      end
      check("t1_busy_fall", busy_fall, mon_cyc[b+8] + 1);
      check("t1_spkt", stat_pkt, 32'd3);
      check("t1_serr", stat_err, 32'd0);

      // T2: loopback len=5 pkts=2 with LFSR backpressure
      cfg_bp = 2'd2;
      tick();
      b  = mon_n;
      sb = stall_bad;
      start(16'd5, 16'd2, 8'h40);
      wait_idle("t2_idle", 400);
      tick();
      check("t2_beats", mon_n - b, 32'd6);
      for (int i = 0; i < 6; i++) begin
         e = t2_base[i];
         check("t2_data", {16'h0, mon_data[b+i]}, {16'h0, e + 8'd1, e});
         check("t2_keep", mon_keep[b+i], 32'(t2_keep[i]));
         check("t2_last", mon_last[b+i], 32'(i == 2 || i == 5));
      end
      check("t2_stall_stable", stall_bad, sb);
      check("t2_spkt", stat_pkt, 32'd2);
      check("t2_serr", stat_err, 32'd0);
      cfg_bp = 2'd0;
      tick();

      // T3: byte counter wrap FE,FF,00,01
      b = mon_n;
      start(16'd4, 16'd1, 8'hFE);
      wait_idle("t3_idle", 50);
      tick();
      check("t3_beats", mon_n - b, 32'd2);
      check("t3_d0", mon_data[b],   32'h0000FFFE);
      check("t3_d1", mon_data[b+1], 32'h00000100);
      check("t3_last1", mon_last[b+1], 32'd1);
      check("t3_spkt", stat_pkt, 32'd1);
      check("t3_serr", stat_err, 32'd0);

      // T4: bench drives RX directly, len=4 seed=0
      loopback = 1'b0;
      b_tx_tready = 1'b1;
      tick();
      start(16'd4, 16'd1, 8'h00);
      check("t4_rdy", rx_tready, 32'd1);
      rx_beat(16'h0001, 2'b11, 1'b0);   // both lanes wrong: one error
      check("t4_err1", stat_err, 32'd1);
      check("t4_pkt1", stat_pkt, 32'd0);
      rx_beat(16'h0002, 2'b01, 1'b1);   // data ok, tlast at 3 of 4 bytes
      check("t4_err2", stat_err, 32'd2);
      check("t4_pkt2", stat_pkt, 32'd1);
      rx_beat(16'h0300, 2'b10, 1'b0);   // data ok, keep has a hole
      check("t4_err3", stat_err, 32'd3);
      rx_beat(16'h0000, 2'b00, 1'b0);   // empty keep
      check("t4_err4", stat_err, 32'd4);
      check("t4_pkt4", stat_pkt, 32'd1);
      wait_idle("t4_idle", 50);
      cfg_bp = 2'd3;
      tick();
      check("bp3_rdy", rx_tready, 32'd0);
      cfg_bp = 2'd1;
      tick();
      check("bp1_a", rx_tready, 32'd1);
      tick();
      check("bp1_b", rx_tready, 32'd0);
      tick();
      check("bp1_c", rx_tready, 32'd1);
      cfg_bp = 2'd0;
      loopback = 1'b1;
      tick();

      // T6: inter-packet gap, len=2 pkts=2
      b = mon_n;
      start(16'd2, 16'd2, 8'h00);
      wait_idle("t6_idle", 60);
      tick();
      check("t6_beats", mon_n - b, 32'd2);
      check("t6_gap", mon_cyc[b+1] - mon_cyc[b] - 1, 32'(GAP_EXP));
      check("t6_spkt", stat_pkt, 32'd2);
      check("t6_serr", stat_err, 32'd0);

      // T5: continuous run, stop mid-packet, then reset during a later run
      b = mon_n;
      start(16'd6, 16'd0, 8'h00);
      wait_beats("t5_wait", b, 4, 50);
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      wait_idle("t5_idle", 50);
      tick();
      check("t5_beats", mon_n - b, 32'd6);
      check("t5_last", mon_last[b+5], 32'd1);
      check("t5_spkt", stat_pkt, 32'd2);
      check("t5_serr", stat_err, 32'd0);
      b = mon_n;
      start(16'd6, 16'd0, 8'h00);
      wait_beats("t5r_wait", b, 1, 50);
      check("t5r_busy", tx_busy, 32'd1);
      rst = 1'b1;
      tick();
      check_all_zero("t5r");
      rst = 1'b0;
      tick();
      check("t5r_busy_after", tx_busy, 32'd0);
      check("t5r_rdy_after", rx_tready, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
